loa_cla_adder_locked_pipe: RTL and testbench

Parametrised, two-stage pipelined lower-part-OR approximate adder with carry lookahead on the exact part and XOR/XNOR logic locking on the carry chain. This is the next generation of the team's locked 16-bit LOA adder. It adds a generic width, a runtime exact/approximate mode, a valid/ready stream interface, and an on-chip serially loaded key register in place of a parallel key bus. It sits on the locked-datapath benchmark path between the operand source and the result checker.

---
 rtl/loa_lock_pkg.sv | 33 +++
 rtl/loa_cla_core.sv | 55 +++++
 rtl/loa_cla_adder_locked_pipe.sv | 108 ++++++++++
 tb/tb_loa_cla_adder_locked_pipe.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loa_lock_pkg.sv
// Shared helpers for the locked LOA adder: key-gate placement on the carry chain
// and the per-position inversion contributed by the key gates.
package loa_lock_pkg;

    localparam int MAX_KEY_W = 256;

    // Carry position (LOWER..WIDTH) that key gate k sits on.
    function automatic int key_pos(input int k, input int width, input int lower);
        return lower + (k % (width - lower + 1));
    endfunction

    // XOR-reduced inversion of all gates chained on one carry position.
    // A gate is XOR when its gold bit is 0 and XNOR when it is 1, so it inverts
    // the carry exactly when its key bit differs from the gold bit.
    function automatic logic key_flip_at(
        input int                   pos,
        input logic [MAX_KEY_W-1:0] key,
        input logic [MAX_KEY_W-1:0] gold,
        input int                   key_w,
        input int                   width,
        input int                   lower
    );
        logic flip;
        flip = 1'b0;
        for (int k = 0; k < MAX_KEY_W; k++) begin
            if (k < key_w && key_pos(k, width, lower) == pos) begin
                flip = flip ^ key[k] ^ gold[k];
            end
        end
        return flip;
    endfunction

endpackage

// File: rtl/loa_cla_core.sv
// Combinational locked adder: OR lower part (LOA mode) or full exact add, with
// generate/propagate carries through the key gates on positions LOWER..WIDTH.
module loa_cla_core
    import loa_lock_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter int               LOWER    = 4,
    parameter int               KEY_W    = 32,
    parameter logic [KEY_W-1:0] KEY_GOLD = '0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             approx,
    input  logic [KEY_W-1:0] key,
    output logic [WIDTH:0]   sum
);

    localparam logic [MAX_KEY_W-1:0] GOLD_EXT = MAX_KEY_W'(KEY_GOLD);

    logic [MAX_KEY_W-1:0] key_ext;
    logic [WIDTH-1:0]     g;
    logic [WIDTH-1:0]     p;
    logic [WIDTH:1]       flip;
    logic                 carry;

    assign key_ext = MAX_KEY_W'(key);
    assign g       = a & b;
    assign p       = a ^ b;

    always_comb begin
        flip = '0;
        for (int pos = 1; pos <= WIDTH; pos++) begin
            flip[pos] = key_flip_at(pos, key_ext, GOLD_EXT, KEY_W, WIDTH, LOWER);
        end
    end

    // The carry into each bit is gated before it is used, so an inverted carry
    // propagates into every later generate/propagate term.
    always_comb begin
        sum   = '0;
        carry = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (approx && i < LOWER) begin
                sum[i] = a[i] | b[i];
                carry  = (i == LOWER - 1) ? g[i] : 1'b0;
            end else begin
                sum[i] = p[i] ^ carry;
                carry  = g[i] | (p[i] & carry);
            end
            carry = carry ^ flip[i+1];
        end
        sum[WIDTH] = carry;
    end

endmodule

// File: rtl/loa_cla_adder_locked_pipe.sv
// Two-stage pipelined locked LOA/exact adder with a serially loaded key register
// and a valid/ready stream on both sides.
module loa_cla_adder_locked_pipe
    import loa_lock_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter int               LOWER    = 4,
    parameter int               KEY_W    = 32,
    parameter logic [KEY_W-1:0] KEY_GOLD = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] add1_i,
    input  logic [WIDTH-1:0] add2_i,
    input  logic             approx_i,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH:0]   result_o,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             key_sin,
    input  logic             key_shift,
    output logic             key_loaded
);

    localparam int CNT_W = $clog2(KEY_W + 1);

    logic [KEY_W-1:0] key_q;
    logic [CNT_W-1:0] shift_cnt;

    logic             a_valid;
    logic [WIDTH-1:0] a_op1;
    logic [WIDTH-1:0] a_op2;
    logic             a_approx;
    logic             b_valid;
    logic [WIDTH:0]   sum_c;
    logic             accept;
    logic             advance;

    // Key register: LSB-first serial load; key_loaded saturates after KEY_W shifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q      <= '0;
            shift_cnt  <= '0;
            key_loaded <= 1'b0;
        end else if (key_shift) begin
            key_q <= {key_sin, key_q[KEY_W-1:1]};
            if (!key_loaded) begin
                shift_cnt <= shift_cnt + 1'b1;
                if (shift_cnt == CNT_W'(KEY_W - 1)) begin
                    key_loaded <= 1'b1;
                end
            end
        end
    end

    // A beat moves on a side when valid && ready are both high at the clock edge;
    // a producer holds its beat until taken. No operand is taken while the key
    // shifts, and stage A advances whenever B is empty or being drained.
    assign advance  = a_valid && (!b_valid || out_ready);
    assign in_ready = !key_shift && (!a_valid || !b_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid  <= 1'b0;
            a_op1    <= '0;
            a_op2    <= '0;
            a_approx <= 1'b0;
        end else if (accept) begin
            a_valid  <= 1'b1;
            a_op1    <= add1_i;
            a_op2    <= add2_i;
            a_approx <= approx_i;
        end else if (advance) begin
            a_valid <= 1'b0;
        end
    end

    loa_cla_core #(
        .WIDTH    (WIDTH),
        .LOWER    (LOWER),
        .KEY_W    (KEY_W),
        .KEY_GOLD (KEY_GOLD)
    ) u_core (
        .a      (a_op1),
        .b      (a_op2),
        .approx (a_approx),
        .key    (key_q),
        .sum    (sum_c)
    );

    // The key value seen by stage B is the one present on the cycle A advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_valid  <= 1'b0;
            result_o <= '0;
        end else if (advance) begin
            b_valid  <= 1'b1;
            result_o <= sum_c;
        end else if (out_ready) begin
            b_valid <= 1'b0;
        end
    end

    assign out_valid = b_valid;

endmodule

// File: tb/tb_loa_cla_adder_locked_pipe.sv
// Directed bench for the locked pipelined LOA adder, WIDTH=16, LOWER=4, KEY_W=32.
module tb_loa_cla_adder_locked_pipe;

    localparam int          WIDTH = 16;
    localparam int          LOWER = 4;
    localparam int          KEY_W = 32;
    localparam logic [31:0] GOLD  = 32'hA5C3_0F96;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] add1 = '0;
    logic [15:0] add2 = '0;
    logic        approx = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [16:0] result_o;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        key_sin = 1'b0;
    logic        key_shift = 1'b0;
    logic        key_loaded;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    loa_cla_adder_locked_pipe #(
        .WIDTH    (WIDTH),
        .LOWER    (LOWER),
        .KEY_W    (KEY_W),
        .KEY_GOLD (GOLD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .add1_i     (add1),
        .add2_i     (add2),
        .approx_i   (approx),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .result_o   (result_o),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .key_sin    (key_sin),
        .key_shift  (key_shift),
        .key_loaded (key_loaded)
    );

    // ---------------- driver tasks ----------------
    task automatic load_key(input logic [31:0] k);
        for (int i = 0; i < KEY_W; i++) begin
            @(negedge clk);
            key_shift = 1'b1;
            key_sin   = k[i];
        end
        @(negedge clk);
        key_shift = 1'b0;
        key_sin   = 1'b0;
    endtask

    task automatic issue_and_wait(input logic [15:0] a, input logic [15:0] b, input logic ap,
                                  output logic [16:0] res, output int cyc);
        @(negedge clk);
        add1     = a;
        add2     = b;
        approx   = ap;
        in_valid = 1'b1;
        cyc      = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            in_valid = 1'b0;
        end while (!out_valid && cyc < 10);
        res = result_o;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2 rst_n = 1'b0;
        #10;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (result_o !== 17'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 00000", result_o); end
        n_checks++; if (key_loaded !== 1'b0) begin n_fail++; $display("FAIL reset_key_loaded: got %b expected 0", key_loaded); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_key_load();
        logic [31:0] k;
        logic        exp_kl;
        k = GOLD;
        // an operand is offered throughout the load and must never be taken
        add1 = 16'h0001; add2 = 16'h0001; approx = 1'b0;
        for (int i = 0; i < KEY_W; i++) begin
            @(negedge clk);
            key_shift = 1'b1;
            key_sin   = k[i];
            in_valid  = 1'b1;
            #1;
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL shift_in_ready[%0d]: got %b expected 0", i, in_ready); end
            @(posedge clk);
            #1;
            exp_kl = (i == KEY_W - 1);
            n_checks++; if (key_loaded !== exp_kl) begin n_fail++; $display("FAIL key_loaded[%0d]: got %b expected %b", i, key_loaded, exp_kl); end
        end
        @(negedge clk);
        key_shift = 1'b0;
        in_valid  = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL shift_no_accept: got out_valid %b expected 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL after_shift_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_golden_loa();
        logic [16:0] res;
        int          cyc;
        issue_and_wait(16'h00FF, 16'h0001, 1'b1, res, cyc);
        n_checks++; if (cyc !== 2) begin n_fail++; $display("FAIL latency: got %0d expected 2", cyc); end
        n_checks++; if (res !== 17'h000FF) begin n_fail++; $display("FAIL loa_00ff_0001: got %h expected 000ff", res); end
        issue_and_wait(16'hFFFF, 16'h0001, 1'b1, res, cyc);
        n_checks++; if (res !== 17'h0FFFF) begin n_fail++; $display("FAIL loa_ffff_0001: got %h expected 0ffff", res); end
        issue_and_wait(16'h0018, 16'h0008, 1'b1, res, cyc);
        n_checks++; if (res !== 17'h00028) begin n_fail++; $display("FAIL loa_0018_0008: got %h expected 00028", res); end
        issue_and_wait(16'h1234, 16'h4321, 1'b1, res, cyc);
        n_checks++; if (res !== 17'h05555) begin n_fail++; $display("FAIL loa_1234_4321: got %h expected 05555", res); end
    endtask

    task automatic test_exact();
        logic [16:0] res;
        int          cyc;
        issue_and_wait(16'hFFFF, 16'h0001, 1'b0, res, cyc);
        n_checks++; if (res !== 17'h10000) begin n_fail++; $display("FAIL exact_ffff_0001: got %h expected 10000", res); end
        issue_and_wait(16'h0018, 16'h0008, 1'b0, res, cyc);
        n_checks++; if (res !== 17'h00020) begin n_fail++; $display("FAIL exact_0018_0008: got %h expected 00020", res); end
        issue_and_wait(16'h8000, 16'h8000, 1'b0, res, cyc);
        n_checks++; if (res !== 17'h10000) begin n_fail++; $display("FAIL exact_8000_8000: got %h expected 10000", res); end
    endtask

    task automatic test_wrong_key();
        logic [16:0] res;
        int          cyc;
        // gate 0 wrong: carry into bit 4 inverted
        load_key(GOLD ^ 32'h0000_0001);
        issue_and_wait(16'h0018, 16'h0008, 1'b1, res, cyc);
        n_checks++; if (res !== 17'h00018) begin n_fail++; $display("FAIL k0_loa_0018: got %h expected 00018", res); end
        issue_and_wait(16'h0018, 16'h0008, 1'b0, res, cyc);
        n_checks++; if (res !== 17'h00010) begin n_fail++; $display("FAIL k0_exact_0018: got %h expected 00010", res); end
        issue_and_wait(16'h0001, 16'h0002, 1'b1, res, cyc);
        n_checks++; if (res !== 17'h00013) begin n_fail++; $display("FAIL k0_loa_0001: got %h expected 00013", res); end
        // gate 12 wrong: sits on the carry-out
        load_key(GOLD ^ 32'h0000_1000);
        n_checks++; if (key_loaded !== 1'b1) begin n_fail++; $display("FAIL key_loaded_sticky: got %b expected 1", key_loaded); end
        issue_and_wait(16'hFFFF, 16'h0001, 1'b1, res, cyc);
        n_checks++; if (res !== 17'h1FFFF) begin n_fail++; $display("FAIL k12_loa_ffff: got %h expected 1ffff", res); end
        issue_and_wait(16'h0001, 16'h0001, 1'b0, res, cyc);
        n_checks++; if (res !== 17'h10002) begin n_fail++; $display("FAIL k12_exact_0001: got %h expected 10002", res); end
        // gates 0 and 13 share bit 4 and cancel each other
        load_key(GOLD ^ 32'h0000_2001);
        issue_and_wait(16'h0018, 16'h0008, 1'b1, res, cyc);
        n_checks++; if (res !== 17'h00028) begin n_fail++; $display("FAIL k0k13_cancel: got %h expected 00028", res); end
        load_key(GOLD);
    endtask

    task automatic test_back_to_back();
        logic [15:0] va [4] = '{16'h00FF, 16'h0018, 16'hFFFF, 16'h1234};
        logic [15:0] vb [4] = '{16'h0001, 16'h0008, 16'h0001, 16'h4321};
        logic [16:0] ve [4] = '{17'h000FF, 17'h00028, 17'h0FFFF, 17'h05555};
        out_ready = 1'b1;
        approx    = 1'b1;
        for (int j = 0; j < 7; j++) begin
            @(negedge clk);
            if (j >= 2 && j <= 5) begin
                n_checks++; if (out_valid !== 1'b1 || result_o !== ve[j-2]) begin
                    n_fail++; $display("FAIL b2b_out[%0d]: got v=%b %h expected v=1 %h", j - 2, out_valid, result_o, ve[j-2]);
                end
            end else begin
                n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle[%0d]: got v=%b expected 0", j, out_valid); end
            end
            if (j < 4) begin
                add1 = va[j]; add2 = vb[j]; in_valid = 1'b1;
                n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d]: got %b expected 1", j, in_ready); end
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_stall();
        approx = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        add1 = 16'h0001; add2 = 16'h0001; in_valid = 1'b1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_rdy0: got %b expected 1", in_ready); end
        @(negedge clk);
        add1 = 16'h00F0; add2 = 16'h0010;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_rdy1: got %b expected 1", in_ready); end
        @(negedge clk);
        add1 = 16'hFFFF; add2 = 16'hFFFF;
        for (int j = 0; j < 3; j++) begin
            if (j > 0) @(negedge clk);
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_full_rdy[%0d]: got %b expected 0", j, in_ready); end
            n_checks++; if (out_valid !== 1'b1 || result_o !== 17'h00002) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got v=%b %h expected v=1 00002", j, out_valid, result_o);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || result_o !== 17'h00100) begin n_fail++; $display("FAIL stall_second: got v=%b %h expected v=1 00100", out_valid, result_o); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || result_o !== 17'h1FFFE) begin n_fail++; $display("FAIL stall_third: got v=%b %h expected v=1 1fffe", out_valid, result_o); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_backpressure();
        logic [15:0] va [8] = '{16'h0001, 16'h00F0, 16'hFFFF, 16'h7FFF, 16'h1234, 16'hAAAA, 16'h8001, 16'h0F0F};
        logic [15:0] vb [8] = '{16'h0001, 16'h0010, 16'hFFFF, 16'h0001, 16'h1111, 16'h5555, 16'h8001, 16'hF0F0};
        logic [16:0] exp_q [$];
        exp_q = '{17'h00002, 17'h00100, 17'h1FFFE, 17'h08000, 17'h02345, 17'h0FFFF, 17'h10002, 17'h0FFFF};
        approx    = 1'b0;
        out_ready = 1'b0;
        fork
            begin : producer
                int  i = 0;
                int  guard = 0;
                logic rdy;
                while (i < 8 && guard < 100) begin
                    @(negedge clk);
                    add1 = va[i]; add2 = vb[i]; in_valid = 1'b1;
                    #1 rdy = in_ready;
                    @(posedge clk);
                    if (rdy) i++;
                    guard++;
                end
                @(negedge clk);
                in_valid = 1'b0;
            end
            begin : monitor
                int          got = 0;
                logic        held_v = 1'b0;
                logic [16:0] held = '0;
                logic [16:0] exp_v;
                for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
                    @(negedge clk);
                    out_ready = ~out_ready;
                    if (held_v) begin
                        n_checks++; if (result_o !== held) begin n_fail++; $display("FAIL bp_stable: got %h expected %h", result_o, held); end
                    end
                    held_v = 1'b0;
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) begin
                            n_checks++; n_fail++; $display("FAIL bp_extra: got %h expected none", result_o);
                        end else begin
                            exp_v = exp_q.pop_front();
                            n_checks++; if (result_o !== exp_v) begin n_fail++; $display("FAIL bp_data[%0d]: got %h expected %h", got, result_o, exp_v); end
                        end
                        got++;
                    end else if (out_valid) begin
                        held   = result_o;
                        held_v = 1'b1;
                    end
                end
                n_checks++; if (got != 8) begin n_fail++; $display("FAIL bp_count: got %0d expected 8", got); end
            end
        join
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_leftover: got %0d expected 0", exp_q.size()); end
        @(negedge clk);
        out_ready = 1'b1;
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b1;
        approx    = 1'b0;
        @(negedge clk);
        add1 = 16'h0001; add2 = 16'h0001; in_valid = 1'b1;
        @(negedge clk);
        add1 = 16'h00F0; add2 = 16'h0010;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_inflight: got %b expected 1", out_valid); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (result_o !== 17'h0) begin n_fail++; $display("FAIL mid_result: got %h expected 00000", result_o); end
        n_checks++; if (key_loaded !== 1'b0) begin n_fail++; $display("FAIL mid_key_loaded: got %b expected 0", key_loaded); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready: got %b expected 1", in_ready); end
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_output[%0d]: got %b expected 0", j, out_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_key_load();
        test_golden_loa();
        test_exact();
        test_wrong_key();
        test_back_to_back();
        test_stall();
        test_backpressure();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
